// File: rtl/alu_md_unit_if.sv
// Request/response bundle for alu_md_unit: operand/opcode request side plus
// the result side, each with its own valid/ready pair.
interface alu_md_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic            alt;
    logic            is_m;
    logic            is_r_type;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out;

    modport master (
        output in_valid, funct3, alt, is_m, is_r_type, in1, in2, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, funct3, alt, is_m, is_r_type, in1, in2, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/alu_md_unit.sv
// Execute unit: single-cycle integer ALU plus iterative RV32M/RV64M
// multiply (shift-add) and divide (restoring), one operation in flight.
module alu_md_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    alu_md_unit_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_reg;
    logic [SHW-1:0]  count_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;
    logic [XLEN-1:0] out_reg;
    logic [XLEN-1:0] hi_reg;
    logic [XLEN-1:0] lo_reg;
    logic [XLEN-1:0] opb_reg;
    logic [XLEN-1:0] special_res_reg;
    logic            special_reg;
    logic            is_div_reg;
    logic            neg_reg;
    logic            rem_neg_reg;
    logic [2:0]      f3_reg;

    // ---------------- ALU and request decode (from live inputs) ----------------
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sra_res;
    logic [XLEN-1:0] alu_res;
    logic            req_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_val;

    assign shamt   = bus.in2[SHW-1:0];
    assign sra_res = $signed(bus.in1) >>> shamt;

    always_comb begin
        alu_res = '0;
        case (bus.funct3)
            3'b000:  alu_res = (bus.is_r_type && bus.alt) ? bus.in1 - bus.in2 : bus.in1 + bus.in2;
            3'b001:  alu_res = bus.in1 << shamt;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.in1) < $signed(bus.in2)};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, bus.in1 < bus.in2};
            3'b100:  alu_res = bus.in1 ^ bus.in2;
            3'b101:  alu_res = bus.alt ? sra_res : bus.in1 >> shamt;
            3'b110:  alu_res = bus.in1 | bus.in2;
            default: alu_res = bus.in1 & bus.in2;
        endcase
    end

    // DIV/REM are signed on funct3[0]=0; MULH/MULHSU take a signed rs1, only MULH a signed rs2.
    always_comb begin
        req_div  = bus.funct3[2];
        a_sgn    = req_div ? ~bus.funct3[0] : (bus.funct3 == 3'b001 || bus.funct3 == 3'b010);
        b_sgn    = req_div ? ~bus.funct3[0] : (bus.funct3 == 3'b001);
        a_neg    = a_sgn & bus.in1[XLEN-1];
        b_neg    = b_sgn & bus.in2[XLEN-1];
        a_mag    = a_neg ? -bus.in1 : bus.in1;
        b_mag    = b_neg ? -bus.in2 : bus.in2;
        div_zero = (bus.in2 == '0);
        div_ovf  = a_sgn && (bus.in1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in2 == '1);
        if (div_zero)
            special_val = bus.funct3[1] ? bus.in1 : '1;
        else
            special_val = bus.funct3[1] ? '0 : bus.in1;
    end

    // ---------------- one iteration of multiply / divide ----------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] step_hi, step_lo;

    assign mul_sum = {1'b0, hi_reg} + {1'b0, (lo_reg[0] ? opb_reg : {XLEN{1'b0}})};
    assign trial   = {hi_reg, lo_reg[XLEN-1]} - {1'b0, opb_reg};

    always_comb begin
        if (is_div_reg) begin
            if (!trial[XLEN]) begin
                step_hi = trial[XLEN-1:0];
                step_lo = {lo_reg[XLEN-2:0], 1'b1};
            end else begin
                step_hi = {hi_reg[XLEN-2:0], lo_reg[XLEN-1]};
                step_lo = {lo_reg[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the state after the final iteration.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, m_res;

    always_comb begin
        prod_fix = neg_reg ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo_fix  = neg_reg ? -step_lo : step_lo;
        rem_fix  = rem_neg_reg ? -step_hi : step_hi;
        case (f3_reg)
            3'b000:         m_res = prod_fix[XLEN-1:0];
            3'b100, 3'b101: m_res = quo_fix;
            3'b110, 3'b111: m_res = rem_fix;
            default:        m_res = prod_fix[2*XLEN-1:XLEN];
        endcase
        if (special_reg)
            m_res = special_res_reg;
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            in_ready_reg    <= 1'b1;
            out_valid_reg   <= 1'b0;
            out_reg         <= '0;
            hi_reg          <= '0;
            lo_reg          <= '0;
            opb_reg         <= '0;
            special_res_reg <= '0;
            special_reg     <= 1'b0;
            is_div_reg      <= 1'b0;
            neg_reg         <= 1'b0;
            rem_neg_reg     <= 1'b0;
            f3_reg          <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!flush && bus.in_valid) begin
                        in_ready_reg <= 1'b0;
                        if (bus.is_m) begin
                            state_reg       <= BUSY;
                            count_reg       <= '0;
                            f3_reg          <= bus.funct3;
                            is_div_reg      <= req_div;
                            hi_reg          <= '0;
                            lo_reg          <= req_div ? a_mag : b_mag;
                            opb_reg         <= req_div ? b_mag : a_mag;
                            neg_reg         <= a_neg ^ b_neg;
                            rem_neg_reg     <= a_neg;
                            special_reg     <= req_div && (div_zero || div_ovf);
                            special_res_reg <= special_val;
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            out_reg       <= alu_res;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state_reg    <= IDLE;
                        in_ready_reg <= 1'b1;
                    end else begin
                        hi_reg    <= step_hi;
                        lo_reg    <= step_lo;
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == SHW'(XLEN-1)) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            out_reg       <= m_res;
                        end
                    end
                end
                default: begin
                    if (flush || bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out       = out_reg;
endmodule

// File: tb/tb_alu_md_unit.sv
// Directed bench for alu_md_unit: vector tables at XLEN=32 and XLEN=64 plus
// hand-written reset, back-pressure and flush sequences.
module tb_alu_md_unit;
    logic clk;
    logic rst_n;
    logic flush;

    alu_md_unit_if #(.XLEN(32)) bus32();
    alu_md_unit_if #(.XLEN(64)) bus64();

    alu_md_unit #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32));
    alu_md_unit #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_m;
        logic [2:0]  f3;
        logic        alt;
        logic        r;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    localparam int N32 = 26;
    localparam int N64 = 15;
    vec_t t32 [N32];
    vec_t t64 [N64];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
        end else begin
            $display("[TB] ok   %s: %h", nm, act);
        end
    endtask

    function automatic logic get_ready(input bit wide);
        return wide ? bus64.in_ready : bus32.in_ready;
    endfunction

    function automatic logic get_valid(input bit wide);
        return wide ? bus64.out_valid : bus32.out_valid;
    endfunction

    function automatic logic [63:0] get_out(input bit wide);
        return wide ? bus64.out : {32'h0, bus32.out};
    endfunction

    // Present a request at a negedge; returns just after the accepting edge.
    task automatic start_op(input bit wide, input vec_t v);
        @(negedge clk);
        check({v.name, " in_ready"}, {63'h0, get_ready(wide)}, 64'd1);
        if (wide) begin
            bus64.in_valid = 1'b1; bus64.funct3 = v.f3; bus64.alt = v.alt;
            bus64.is_m = v.is_m; bus64.is_r_type = v.r; bus64.in1 = v.a; bus64.in2 = v.b;
        end else begin
            bus32.in_valid = 1'b1; bus32.funct3 = v.f3; bus32.alt = v.alt;
            bus32.is_m = v.is_m; bus32.is_r_type = v.r; bus32.in1 = v.a[31:0]; bus32.in2 = v.b[31:0];
        end
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0; bus64.in_valid = 1'b0;
        bus32.in1 = 32'hDEADBEEF; bus32.in2 = 32'hCAFEF00D;
        bus64.in1 = 64'hDEADBEEF_DEADBEEF; bus64.in2 = 64'hCAFEF00D_CAFEF00D;
    endtask

    // Count negedges until out_valid, bounded.
    task automatic wait_valid(input bit wide, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!get_valid(wide) && lat < 200);
    endtask

    task automatic do_op(input bit wide, input vec_t v);
        int lat;
        int exp_lat;
        logic [63:0] exp_val;
        exp_lat = v.is_m ? (wide ? 65 : 33) : 1;
        exp_val = wide ? v.exp : (v.exp & 64'hFFFF_FFFF);
        start_op(wide, v);
        wait_valid(wide, lat);
        check({v.name, " latency"}, 64'(lat), 64'(exp_lat));
        check({v.name, " result"}, get_out(wide), exp_val);
        @(posedge clk);
    endtask

    initial begin
        int lat;
        int bad;
        logic [63:0] snap;
        vec_t v;

        t32[0]  = '{"ADD",        1'b0, 3'b000, 1'b0, 1'b1, 64'd5, 64'd7, 64'd12};
        t32[1]  = '{"SUB",        1'b0, 3'b000, 1'b1, 1'b1, 64'd5, 64'd7, 64'hFFFFFFFE};
        t32[2]  = '{"ADDI alt",   1'b0, 3'b000, 1'b1, 1'b0, 64'd5, 64'd7, 64'd12};
        t32[3]  = '{"SLL 31",     1'b0, 3'b001, 1'b0, 1'b1, 64'd1, 64'h3F, 64'h80000000};
        t32[4]  = '{"SLT",        1'b0, 3'b010, 1'b0, 1'b1, 64'hFFFFFFFF, 64'd1, 64'd1};
        t32[5]  = '{"SLTU",       1'b0, 3'b011, 1'b0, 1'b1, 64'hFFFFFFFF, 64'd1, 64'd0};
        t32[6]  = '{"XOR",        1'b0, 3'b100, 1'b0, 1'b1, 64'hF0F0F0F0, 64'hFF00FF00, 64'h0FF00FF0};
        t32[7]  = '{"SRL",        1'b0, 3'b101, 1'b0, 1'b1, 64'h80000000, 64'h24, 64'h08000000};
        t32[8]  = '{"SRA",        1'b0, 3'b101, 1'b1, 1'b1, 64'h80000000, 64'h24, 64'hF8000000};
        t32[9]  = '{"OR",         1'b0, 3'b110, 1'b0, 1'b1, 64'h0F00, 64'h00F0, 64'h0FF0};
        t32[10] = '{"AND",        1'b0, 3'b111, 1'b0, 1'b1, 64'hFF00FF00, 64'h0FF00FF0, 64'h0F000F00};
        t32[11] = '{"MUL",        1'b1, 3'b000, 1'b0, 1'b1, 64'h12345678, 64'h10, 64'h23456780};
        t32[12] = '{"MULH -1-1",  1'b1, 3'b001, 1'b0, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h0};
        t32[13] = '{"MULHU",      1'b1, 3'b011, 1'b0, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE};
        t32[14] = '{"MULHSU",     1'b1, 3'b010, 1'b0, 1'b1, 64'hFFFFFFFF, 64'd2, 64'hFFFFFFFF};
        t32[15] = '{"MULH minmin",1'b1, 3'b001, 1'b0, 1'b1, 64'h80000000, 64'h80000000, 64'h40000000};
        t32[16] = '{"DIV -7/2",   1'b1, 3'b100, 1'b0, 1'b1, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD};
        t32[17] = '{"REM -7/2",   1'b1, 3'b110, 1'b0, 1'b1, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF};
        t32[18] = '{"DIV 7/-2",   1'b1, 3'b100, 1'b0, 1'b1, 64'd7, 64'hFFFFFFFE, 64'hFFFFFFFD};
        t32[19] = '{"REM 7/-2",   1'b1, 3'b110, 1'b0, 1'b1, 64'd7, 64'hFFFFFFFE, 64'd1};
        t32[20] = '{"DIVU 7/0",   1'b1, 3'b101, 1'b0, 1'b1, 64'd7, 64'd0, 64'hFFFFFFFF};
        t32[21] = '{"REM 7/0",    1'b1, 3'b110, 1'b0, 1'b1, 64'd7, 64'd0, 64'd7};
        t32[22] = '{"DIV ovf",    1'b1, 3'b100, 1'b0, 1'b1, 64'h80000000, 64'hFFFFFFFF, 64'h80000000};
        t32[23] = '{"REM ovf",    1'b1, 3'b110, 1'b0, 1'b1, 64'h80000000, 64'hFFFFFFFF, 64'd0};
        t32[24] = '{"DIVU 100/7", 1'b1, 3'b101, 1'b0, 1'b1, 64'd100, 64'd7, 64'd14};
        t32[25] = '{"REMU big",   1'b1, 3'b111, 1'b0, 1'b1, 64'h80000000, 64'hFFFFFFFF, 64'h80000000};

        t64[0]  = '{"64 SUB",     1'b0, 3'b000, 1'b1, 1'b1, 64'd5, 64'd7, 64'hFFFFFFFF_FFFFFFFE};
        t64[1]  = '{"64 SLT",     1'b0, 3'b010, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'd1};
        t64[2]  = '{"64 SLTU",    1'b0, 3'b011, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'd0};
        t64[3]  = '{"64 SRA 4",   1'b0, 3'b101, 1'b1, 1'b1, 64'hFFFFFFFF_80000000, 64'h44, 64'hFFFFFFFF_F8000000};
        t64[4]  = '{"64 SRA 36",  1'b0, 3'b101, 1'b1, 1'b1, 64'hFFFFFFFF_80000000, 64'h24, 64'hFFFFFFFF_FFFFFFFF};
        t64[5]  = '{"64 SRL 4",   1'b0, 3'b101, 1'b0, 1'b1, 64'h80000000_00000000, 64'h44, 64'h08000000_00000000};
        t64[6]  = '{"64 SLL 63",  1'b0, 3'b001, 1'b0, 1'b1, 64'd1, 64'h7F, 64'h80000000_00000000};
        t64[7]  = '{"64 DIV",     1'b1, 3'b100, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFF9, 64'd2, 64'hFFFFFFFF_FFFFFFFD};
        t64[8]  = '{"64 REM",     1'b1, 3'b110, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFF9, 64'd2, 64'hFFFFFFFF_FFFFFFFF};
        t64[9]  = '{"64 DIVU /0", 1'b1, 3'b101, 1'b0, 1'b1, 64'd7, 64'd0, 64'hFFFFFFFF_FFFFFFFF};
        t64[10] = '{"64 REM /0",  1'b1, 3'b110, 1'b0, 1'b1, 64'd7, 64'd0, 64'd7};
        t64[11] = '{"64 DIV ovf", 1'b1, 3'b100, 1'b0, 1'b1, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000000};
        t64[12] = '{"64 REM ovf", 1'b1, 3'b110, 1'b0, 1'b1, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 64'd0};
        t64[13] = '{"64 MULHU",   1'b1, 3'b011, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFE};
        t64[14] = '{"64 MUL",     1'b1, 3'b000, 1'b0, 1'b1, 64'h12345678, 64'h10, 64'h1_23456780};

        rst_n = 1'b0;
        flush = 1'b0;
        bus32.in_valid = 1'b0; bus32.funct3 = '0; bus32.alt = 1'b0; bus32.is_m = 1'b0;
        bus32.is_r_type = 1'b0; bus32.in1 = '0; bus32.in2 = '0; bus32.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.funct3 = '0; bus64.alt = 1'b0; bus64.is_m = 1'b0;
        bus64.is_r_type = 1'b0; bus64.in1 = '0; bus64.in2 = '0; bus64.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset out_valid", {63'h0, bus32.out_valid}, 64'd0);
        check("reset in_ready",  {63'h0, bus32.in_ready},  64'd1);
        check("reset out",       get_out(1'b0),            64'd0);
        check("reset64 out",     get_out(1'b1),            64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < N32; i++) do_op(1'b0, t32[i]);
        for (int i = 0; i < N64; i++) do_op(1'b1, t64[i]);

        // Asynchronous reset in the middle of a DIV: nothing must emerge afterwards.
        v = '{"rst DIV", 1'b1, 3'b100, 1'b0, 1'b1, 64'h64, 64'h7, 64'hE};
        start_op(1'b0, v);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst mid-op out_valid", {63'h0, bus32.out_valid}, 64'd0);
        check("rst mid-op in_ready",  {63'h0, bus32.in_ready},  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus32.out_valid) bad++;
        end
        check("rst no late result", 64'(bad), 64'd0);

        // Back-pressure: result must hold for 10 stalled cycles.
        bus32.out_ready = 1'b0;
        v = '{"bp MULHU", 1'b1, 3'b011, 1'b0, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE};
        start_op(1'b0, v);
        wait_valid(1'b0, lat);
        check("bp latency", 64'(lat), 64'd33);
        check("bp result", get_out(1'b0), 64'hFFFFFFFE);
        snap = get_out(1'b0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (get_out(1'b0) !== snap || bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0) bad++;
        end
        check("bp stall stable", 64'(bad), 64'd0);
        bus32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp consumed", {63'h0, bus32.out_valid}, 64'd0);

        // Flush during BUSY cycle 5, then a plain ADD.
        v = '{"fl DIV", 1'b1, 3'b100, 1'b0, 1'b1, 64'd100, 64'd7, 64'd14};
        start_op(1'b0, v);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy out_valid", {63'h0, bus32.out_valid}, 64'd0);
        check("flush busy in_ready",  {63'h0, bus32.in_ready},  64'd1);
        v = '{"post-flush ADD", 1'b0, 3'b000, 1'b0, 1'b1, 64'd1, 64'd1, 64'd2};
        do_op(1'b0, v);

        // Flush in IDLE blocks the same-cycle request.
        @(negedge clk);
        bus32.in_valid = 1'b1; bus32.is_m = 1'b0; bus32.funct3 = 3'b000;
        bus32.in1 = 32'd3; bus32.in2 = 32'd4;
        flush = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush idle out_valid", {63'h0, bus32.out_valid}, 64'd0);
        check("flush idle in_ready",  {63'h0, bus32.in_ready},  64'd1);

        // Flush while DONE drops the result even with out_ready low.
        bus32.out_ready = 1'b0;
        v = '{"fl done ADD", 1'b0, 3'b000, 1'b0, 1'b1, 64'd2, 64'd2, 64'd4};
        start_op(1'b0, v);
        @(negedge clk);
        check("fl done valid", {63'h0, bus32.out_valid}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus32.out_ready = 1'b1;
        check("flush done out_valid", {63'h0, bus32.out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
